// File: rtl/fib_pkg.sv
// fib_pkg: values shared by the fib-stage trace FIFO.
//   W_DEFAULT / DEPTH_DEFAULT : default operand width and entry count.
//   *_LSB / *_BIT             : field offsets of the packed entry
//                               {sum_ok, selector, m, n, x} at the default width.
//   offset functions          : the same offsets for any operand width w.
package fib_pkg;

  localparam int unsigned W_DEFAULT     = 11;
  localparam int unsigned DEPTH_DEFAULT = 8;

  function automatic int unsigned x_lsb(int unsigned w);
    return 0 * w;
  endfunction

  function automatic int unsigned n_lsb(int unsigned w);
    return w;
  endfunction

  function automatic int unsigned m_lsb(int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned sel_bit(int unsigned w);
    return 3 * w;
  endfunction

  function automatic int unsigned sum_ok_bit(int unsigned w);
    return 3 * w + 1;
  endfunction

  localparam int unsigned X_LSB      = x_lsb(W_DEFAULT);
  localparam int unsigned N_LSB      = n_lsb(W_DEFAULT);
  localparam int unsigned M_LSB      = m_lsb(W_DEFAULT);
  localparam int unsigned SEL_BIT    = sel_bit(W_DEFAULT);
  localparam int unsigned SUM_OK_BIT = sum_ok_bit(W_DEFAULT);

endpackage

// File: rtl/fib_trace_fifo_if.sv
// fib_trace_fifo_if: sample-in and entry-out handshake of the trace FIFO.
//   in_valid, selector, m, n, x : sample from the fib stage
//   out_valid, out_ready        : head-entry handshake
//   out_data                    : head entry {sum_ok, selector, m, n, x}
// master = producer/consumer side, slave = the FIFO.
interface fib_trace_fifo_if
  import fib_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
);

  logic           in_valid;
  logic           selector;
  logic [W-1:0]   m;
  logic [W-1:0]   n;
  logic [W-1:0]   x;
  logic           out_valid;
  logic           out_ready;
  logic [3*W+1:0] out_data;

  modport master (
    output in_valid, selector, m, n, x, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, selector, m, n, x, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers and occupancy flags of a DEPTH-entry FIFO.
//   clk, rst      : clock, asynchronous active-low reset
//   push, pop     : already-qualified write / read strobes (push only when
//                   not full, pop only when not empty)
//   wr_ptr,rd_ptr : clog2(DEPTH)+1 bit pointers, wrapping modulo 2*DEPTH
//   full, empty   : occupancy flags
//   count         : wr_ptr - rd_ptr
module fifo_ptr_ctrl #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   wr_ptr,
  output logic [$clog2(DEPTH):0]   rd_ptr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // The extra MSB tells a full FIFO (lap ahead) from an empty one.
  always_comb begin
    wr_ptr = wr_ptr_q;
    rd_ptr = rd_ptr_q;
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
             (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    count  = wr_ptr_q - rd_ptr_q;
  end

endmodule

// File: rtl/fib_trace_fifo.sv
// fib_trace_fifo: captures fib-stage samples with an (m + n) mod 2^W == x
// check into a first-word-fall-through FIFO.
//   clk, rst  : clock, asynchronous active-low reset
//   bus       : slave side of fib_trace_fifo_if (sample in, entry out)
//   count     : current occupancy
//   drop_cnt  : samples lost to a full FIFO, saturating at 16'hFFFF
//   full,empty: occupancy flags
module fib_trace_fifo
  import fib_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  fib_trace_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = 3 * W + 2;

  logic [W-1:0]  sum_w;
  logic          sum_ok;
  logic [EW-1:0] entry_d;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [EW-1:0] mem_q [DEPTH];

  // W-bit sum: the carry out of m + n is discarded by construction.
  always_comb begin
    sum_w  = bus.m + bus.n;
    sum_ok = (sum_w == bus.x);
  end

  always_comb begin
    entry_d                          = '0;
    entry_d[sum_ok_bit(W)]           = sum_ok;
    entry_d[sel_bit(W)]              = bus.selector;
    entry_d[m_lsb(W) +: W]           = bus.m;
    entry_d[n_lsb(W) +: W]           = bus.n;
    entry_d[x_lsb(W) +: W]           = bus.x;
  end

  // full/empty come straight from flops, so out_ready never reaches the
  // write side combinationally.
  always_comb begin
    push = bus.in_valid & ~full;
    pop  = bus.out_ready & ~empty;
  end

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Masking rather than slicing keeps every pointer bit referenced.
  always_comb begin
    wr_idx = AW'(wr_ptr & PW'(DEPTH - 1));
    rd_idx = AW'(rd_ptr & PW'(DEPTH - 1));
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= entry_d;
  end

  // A write into a full FIFO is lost even when a read retires the same edge.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.in_valid && full && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  always_comb begin
    drop_cnt      = drop_cnt_q;
    bus.out_valid = ~empty;
    bus.out_data  = mem_q[rd_idx];
  end

endmodule

// File: tb/tb_fib_trace_fifo.sv
module tb_fib_trace_fifo;
  import fib_pkg::*;

  localparam int unsigned W     = W_DEFAULT;
  localparam int unsigned DEPTH = DEPTH_DEFAULT;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned EW    = 3 * W + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          full;
  logic          empty;

  fib_trace_fifo_if #(.W(W)) bus ();

  fib_trace_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .drop_cnt (drop_cnt),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard and occupancy model.
  logic [EW-1:0] exp_q[$];
  int            model_cnt = 0;
  int            drop_exp  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_entry(input bit sel, input int unsigned m,
                                                input int unsigned n, input int unsigned x);
    int unsigned  s;
    bit           ok;
    logic [W-1:0] mm, nn, xx;
    s  = (m + n) % (1 << W);
    ok = (s == x);
    mm = m[W-1:0];
    nn = n[W-1:0];
    xx = x[W-1:0];
    return {ok, sel, mm, nn, xx};
  endfunction

  task automatic check_status();
    chk("count",     longint'(count),         longint'(model_cnt));
    chk("empty",     longint'(empty),         longint'(model_cnt == 0));
    chk("full",      longint'(full),          longint'(model_cnt == int'(DEPTH)));
    chk("out_valid", longint'(bus.out_valid), longint'(model_cnt != 0));
    chk("drop_cnt",  longint'(drop_cnt),      longint'(drop_exp));
  endtask

  // Drives one cycle of inputs and predicts the outcome of the coming edge.
  task automatic drive(input bit iv, input bit sel, input int unsigned m,
                       input int unsigned n, input int unsigned x, input bit rdy);
    bit acc, rd;
    bus.in_valid  = iv;
    bus.selector  = sel;
    bus.m         = m[W-1:0];
    bus.n         = n[W-1:0];
    bus.x         = x[W-1:0];
    bus.out_ready = rdy;
    acc = iv && (model_cnt < int'(DEPTH));
    rd  = rdy && (model_cnt > 0);
    if (acc) exp_q.push_back(model_entry(sel, m, n, x));
    if (iv && !acc && drop_exp < 65535) drop_exp++;
    model_cnt = model_cnt + int'(acc) - int'(rd);
  endtask

  task automatic step(input bit iv, input bit sel, input int unsigned m,
                      input int unsigned n, input int unsigned x, input bit rdy);
    @(posedge clk);
    #1;
    check_status();
    drive(iv, sel, m, n, x, rdy);
  endtask

  task automatic rnd_step(input bit iv, input bit rdy);
    int unsigned m, n, x;
    m = $urandom_range(0, (1 << W) - 1);
    n = $urandom_range(0, (1 << W) - 1);
    if ($urandom_range(0, 1) == 1) x = (m + n) % (1 << W);
    else                           x = $urandom_range(0, (1 << W) - 1);
    step(iv, 1'($urandom_range(0, 1)), m, n, x, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(2 * DEPTH) + 2 && model_cnt != 0; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every accepted head entry is compared with the scoreboard front.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_data: got 0x%0h expected no entry at %0t", bus.out_data, $time);
      end else begin
        chk("out_data", longint'(bus.out_data), longint'(exp_q.pop_front()));
      end
    end
  end

  logic [EW-1:0] e_first;

  initial begin
    e_first = {1'b1, 1'b1, 11'd3, 11'd5, 11'd8};
    drive(0, 0, 0, 0, 0, 0);
    exp_q.delete();
    model_cnt = 0;
    drop_exp  = 0;

    #12;
    check_status();
    @(negedge clk);
    rst = 1'b1;

    // Single sample, visible one edge later.
    step(1, 1, 3, 5, 8, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("first_entry", longint'(bus.out_data), longint'(e_first));
    drain();

    // Wrapping sum versus a genuine mismatch.
    step(1, 0, 2047, 1, 0, 0);
    step(1, 0, 4, 4, 9, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("sum_ok_wrap", longint'(bus.out_data[EW-1]), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("sum_ok_bad", longint'(bus.out_data[EW-1]), 0);
    drain();

    // Nine writes into eight entries, then drain in order.
    for (int i = 0; i < 9; i++) rnd_step(1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("overflow_full", longint'(full), 1);
    chk("overflow_drop", longint'(drop_cnt), 1);
    drain();

    // Full with simultaneous write and read.
    for (int i = 0; i < int'(DEPTH); i++) rnd_step(1, 0);
    rnd_step(1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("full_rw_count", longint'(count), longint'(DEPTH - 1));
    chk("full_rw_drop", longint'(drop_cnt), 2);
    drain();

    // Streaming: pointers lap the array while occupancy stays at one.
    rnd_step(1, 0);
    for (int i = 0; i < 20; i++) rnd_step(1, 1);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++)
      rnd_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    drain();

    // Asynchronous reset between edges with five entries held.
    for (int i = 0; i < 5; i++) rnd_step(1, 0);
    @(posedge clk);
    #1;
    check_status();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_out_valid", longint'(bus.out_valid), 0);
    chk("async_count",     longint'(count),         0);
    chk("async_drop",      longint'(drop_cnt),      0);
    chk("async_empty",     longint'(empty),         1);
    chk("async_full",      longint'(full),          0);
    exp_q.delete();
    model_cnt = 0;
    drop_exp  = 0;
    // Write presented during reset lands on the first edge after release.
    drive(1, 1, 3, 5, 8, 0);
    #3;
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk("post_reset_entry", longint'(bus.out_data), longint'(e_first));
    drain();

    chk("scoreboard_left", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fib_trace_fifo.md
FIB_TRACE_FIFO -- requirements
Module: fib_trace_fifo

Interface
REQ-001 Parameter W, default 11, sets the width of each sampled operand (m, n, x).
REQ-002 Parameter DEPTH, default 8, sets the FIFO entry count; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  the upstream fib stage presents a sample this cycle.
REQ-006 selector  input  1  selector value that produced the sample.
REQ-007 m, n, x  input  W each  fib-stage outputs being sampled.
REQ-008 out_valid  output  1  the head entry is available.
REQ-009 out_ready  input  1  the consumer accepts the head entry.
REQ-010 out_data  output  3*W+2  head entry, packed as {sum_ok, selector, m, n, x}.
REQ-011 count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 drop_cnt  output  16  number of samples lost to a full FIFO; saturates at 16'hFFFF.
REQ-013 full, empty  output  1 each  occupancy flags.

Function
REQ-014 The block SHALL compute sum_ok = ((m + n) mod 2^W) == x combinationally at capture; the carry out of m + n SHALL be discarded.
REQ-015 Write: when in_valid=1 and the FIFO is not full, the block SHALL store the packed entry at wr_ptr on that edge.
REQ-016 Read: when out_valid=1 and out_ready=1, the block SHALL advance rd_ptr on that edge.
REQ-017 out_data SHALL be driven combinationally from the entry at rd_ptr, with zero read latency (first-word fall-through); an entry written at edge k SHALL be visible with out_valid=1 after edge k.
REQ-018 Pointers SHALL be clog2(DEPTH)+1 bits wide, and wrap modulo 2*DEPTH; full = (MSBs differ and low bits equal), empty = (pointers equal).
REQ-019 Simultaneous write and read when full: the read SHALL complete; the write SHALL be dropped and counted, because full is evaluated before the edge.
REQ-020 Simultaneous write and read when empty: only the write SHALL take effect, since out_valid=0 and no bypass path exists.
REQ-021 Simultaneous write and read when neither full nor empty: both SHALL occur, and count SHALL be unchanged.
REQ-022 When in_valid=1 and full=1 with no read, the sample SHALL be discarded and drop_cnt SHALL increment, unless it is already 16'hFFFF.
REQ-023 out_valid SHALL equal ~empty; count SHALL equal wr_ptr - rd_ptr.
REQ-024 When out_valid=0, out_data contents are don't-care.

Reset
REQ-025 While rst=0, wr_ptr, rd_ptr, count and drop_cnt SHALL be 0; empty=1, full=0 and out_valid=0.
REQ-026 Asserting reset mid-operation SHALL discard all stored entries immediately, with no clock edge required.
REQ-027 The storage array SHALL NOT be reset.
REQ-028 The first write SHALL be possible on the first rising edge after rst returns high.

Structure
REQ-029 A shared package fib_pkg SHALL hold the W default, the DEPTH default and the packed entry field offsets (SUM_OK_BIT, SEL_BIT, M_LSB, N_LSB, X_LSB).
REQ-030 The pointer and flag logic SHALL be one sub-module, fifo_ptr_ctrl (inputs push, pop; outputs wr_ptr, rd_ptr, full, empty, count); storage and drop_cnt SHALL remain in fib_trace_fifo.
REQ-031 There SHALL be no latches and no combinational path from out_ready to in-side signals.

Verification
REQ-032 Reset then a single sample m=3, n=5, x=8, selector=1 -> after 1 edge out_valid=1, out_data={1,1,3,5,8}, count=1.
REQ-033 Sample m=2047, n=1, x=0 -> sum_ok=1 (wrap); a following sample m=4, n=4, x=9 -> sum_ok=0.
REQ-034 Nine writes with DEPTH=8 and out_ready=0 -> full=1 after the 8th, the 9th is dropped, drop_cnt=1; draining 8 entries returns them in order.
REQ-035 Full FIFO with in_valid=1 and out_ready=1 together -> count stays 7, drop_cnt increments, head advances.
REQ-036 Continuous write and read for 20 cycles -> pointers wrap twice, data order is preserved, and empty/full are never falsely set.
REQ-037 Assert rst=0 asynchronously between edges with count=5 -> out_valid=0 and count=0 without waiting for a clock edge; drop_cnt=0.
